// File: rtl/vec_alu_seq.sv
// Element-serial vector integer execute stage: walks one SEW-wide element per clock
// from vstart up to min(vl, MAX_VLEN/sew)-1 and returns the merged result vector.
module vec_alu_seq #(
  parameter int MAX_VLEN = 512,
  parameter int XLEN     = 32,
  parameter int IDX_W    = $clog2(MAX_VLEN/8)+1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  ready,
  input  logic [2:0]            op,
  input  logic [6:0]            sew,
  input  logic [XLEN-1:0]       vl,
  input  logic [XLEN-1:0]       vstart,
  input  logic                  vm,
  input  logic [MAX_VLEN/8-1:0] v0_mask,
  input  logic [MAX_VLEN-1:0]   op1,
  input  logic [MAX_VLEN-1:0]   op2,
  input  logic [MAX_VLEN-1:0]   dst_data,
  output logic [MAX_VLEN-1:0]   result,
  output logic                  done,
  output logic                  sew_err
);

  localparam int MW    = MAX_VLEN/8;
  localparam int OFF_W = $clog2(MAX_VLEN)+1;
  localparam logic [IDX_W-1:0] E8  = IDX_W'(MAX_VLEN/8);
  localparam logic [IDX_W-1:0] E16 = IDX_W'(MAX_VLEN/16);
  localparam logic [IDX_W-1:0] E32 = IDX_W'(MAX_VLEN/32);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;

  state_t                state_r, state_nxt_s;
  logic                  ready_r, done_r, sew_err_r;
  logic                  ready_nxt_s, done_nxt_s;
  logic [2:0]            op_r;
  logic [1:0]            lg_r, lg_s;
  logic                  vm_r;
  logic [MW-1:0]         mask_r;
  logic [MAX_VLEN-1:0]   op1_r, op2_r, result_r, wr_s;
  logic [IDX_W-1:0]      idx_r, elems_r, elems_s, max_elems_s;
  logic                  sew_ok_s, skip_s, last_s, elem_en_s;
  logic [OFF_W-1:0]      off_s;
  logic [31:0]           emask_s, a_s, b_s, f_raw_s, f_s;
  logic [4:0]            shmask_s;

  assign ready   = ready_r;
  assign done    = done_r;
  assign sew_err = sew_err_r;
  assign result  = result_r;

  // Decode the requested SEW and clamp the element count against the register width.
  always_comb begin
    sew_ok_s    = 1'b0;
    lg_s        = 2'd0;
    max_elems_s = {IDX_W{1'b0}};
    case (sew)
      7'd8:    begin sew_ok_s = 1'b1; lg_s = 2'd0; max_elems_s = E8;  end
      7'd16:   begin sew_ok_s = 1'b1; lg_s = 2'd1; max_elems_s = E16; end
      7'd32:   begin sew_ok_s = 1'b1; lg_s = 2'd2; max_elems_s = E32; end
      default: begin sew_ok_s = 1'b0; lg_s = 2'd0; max_elems_s = {IDX_W{1'b0}}; end
    endcase
    if (vl >= XLEN'(max_elems_s)) begin
      elems_s = max_elems_s;
    end else begin
      elems_s = vl[IDX_W-1:0];
    end
    skip_s = !sew_ok_s || (vstart >= XLEN'(elems_s));
    last_s = (idx_r == (elems_r - IDX_W'(1)));
  end

  // Next-state logic and the next values of the registered handshake outputs.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = skip_s ? ST_DONE : ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
    ready_nxt_s = (state_nxt_s == ST_IDLE);
    done_nxt_s  = (state_nxt_s == ST_DONE);
  end

  // State register with registered ready/done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= ready_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Extract the current element, apply the operation and merge it back in place.
  always_comb begin
    case (lg_r)
      2'd0:    begin emask_s = 32'h0000_00FF; shmask_s = 5'd7;  end
      2'd1:    begin emask_s = 32'h0000_FFFF; shmask_s = 5'd15; end
      2'd2:    begin emask_s = 32'hFFFF_FFFF; shmask_s = 5'd31; end
      default: begin emask_s = 32'hFFFF_FFFF; shmask_s = 5'd31; end
    endcase
    off_s = OFF_W'(idx_r) << (OFF_W'(3) + OFF_W'(lg_r));
    a_s   = 32'(op1_r >> off_s) & emask_s;
    b_s   = 32'(op2_r >> off_s) & emask_s;
    case (op_r)
      3'd0:    f_raw_s = a_s + b_s;
      3'd1:    f_raw_s = a_s - b_s;
      3'd2:    f_raw_s = a_s & b_s;
      3'd3:    f_raw_s = a_s | b_s;
      3'd4:    f_raw_s = a_s ^ b_s;
      3'd5:    f_raw_s = (a_s < b_s) ? a_s : b_s;
      3'd6:    f_raw_s = (a_s > b_s) ? a_s : b_s;
      3'd7:    f_raw_s = a_s << (b_s[4:0] & shmask_s);
      default: f_raw_s = 32'd0;
    endcase
    f_s       = f_raw_s & emask_s;
    elem_en_s = vm_r | 1'(mask_r >> idx_r);
    wr_s      = (result_r & ~(MAX_VLEN'(emask_s) << off_s)) | (MAX_VLEN'(f_s) << off_s);
  end

  // Operand capture on acceptance and per-element result update while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r  <= {MAX_VLEN{1'b0}};
      op1_r     <= {MAX_VLEN{1'b0}};
      op2_r     <= {MAX_VLEN{1'b0}};
      mask_r    <= {MW{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
      elems_r   <= {IDX_W{1'b0}};
      op_r      <= 3'd0;
      lg_r      <= 2'd0;
      vm_r      <= 1'b0;
      sew_err_r <= 1'b0;
    end else if (state_r == ST_IDLE && start) begin
      result_r  <= dst_data;
      op1_r     <= op1;
      op2_r     <= op2;
      mask_r    <= v0_mask;
      idx_r     <= vstart[IDX_W-1:0];
      elems_r   <= elems_s;
      op_r      <= op;
      lg_r      <= lg_s;
      vm_r      <= vm;
      sew_err_r <= !sew_ok_s;
    end else if (state_r == ST_BUSY) begin
      if (elem_en_s) begin
        result_r <= wr_s;
      end
      idx_r <= idx_r + IDX_W'(1);
    end
  end

endmodule
